// File: rtl/cu_if.sv
`default_nettype none
// ============================================================================
// Module   : cu_if
// Purpose  : CU instruction fetch stage. It owns the PC, issues one word read
//            per fetch, and hands Cu_IR/Cu_PC to CU_ID with a Fetch_ready pulse.
// Options  : CU_IF_MISALIGN_CHECK_EN makes a misaligned fetch PC fatal.
// Revision : 1.0
// ============================================================================
module cu_if #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_advance,
  input  logic [31:0] pc_increment,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  input  logic        IDU_stall,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic [31:0] Cu_IR,
  output logic [31:0] Cu_PC,
  output logic        Fetch_ready,
  output logic        fetch_busy,
  output logic        fetch_fault
);

  localparam int unsigned      CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

`ifdef CU_IF_MISALIGN_CHECK_EN
  localparam bit CHECK_ALIGN = 1'b1;
`else
  localparam bit CHECK_ALIGN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e           state_q;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, cpc_q, addr_q;
  logic [CNT_W-1:0] tmo_q;
  logic             squash_q, req_q, ready_q, busy_q, fault_q;
  logic             misalign_d;

  // A redirect is honoured in every live state; a plain step only in IDLE.
  always_comb begin
    pc_d = pc_q;
    if (state_q != S_FAULT && pc_load)
      pc_d = pc_target;
    else if (state_q == S_IDLE && pc_advance)
      pc_d = pc_q + pc_increment;
  end

  assign misalign_d = CHECK_ALIGN && (pc_d[1:0] != 2'b00);

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= NOP_INSTR;
      cpc_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      tmo_q    <= '0;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      pc_q    <= pc_d;
      case (state_q)
        S_IDLE: begin
          if (fetch_start) begin
            state_q <= S_REQ;
            busy_q  <= 1'b1;
            req_q   <= !misalign_d;
            addr_q  <= {pc_d[31:2], 2'b00};
          end
        end
        S_REQ: begin
          tmo_q <= '0;
          if (CHECK_ALIGN && (pc_q[1:0] != 2'b00)) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            // The request is already on the bus, so a redirect here squashes it.
            state_q  <= S_WAIT;
            squash_q <= pc_load;
          end
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            if (squash_q || pc_load) begin
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
              squash_q <= 1'b0;
            end else begin
              ir_q  <= mem_rd_data;
              cpc_q <= pc_q;
              if (!IDU_stall) begin
                ready_q <= 1'b1;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_HOLD;
              end
            end
          end else begin
            if (pc_load)
              squash_q <= 1'b1;
            if (tmo_q == CNT_LAST) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (pc_load) begin
            ir_q    <= NOP_INSTR;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (!IDU_stall) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_rd_req  = req_q;
  assign mem_addr    = addr_q;
  assign Cu_IR       = ir_q;
  assign Cu_PC       = cpc_q;
  assign Fetch_ready = ready_q;
  assign fetch_busy  = busy_q;
  assign fetch_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_cu_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_if
// Purpose  : Self-checking bench for cu_if: directed fetch scenarios followed
//            by randomized fetch transactions against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_cu_if;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned MEM_TIMEOUT = 16;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0, pc_advance = 1'b0, pc_load = 1'b0;
  logic        IDU_stall = 1'b0, mem_rd_valid = 1'b0;
  logic [31:0] pc_increment = '0, pc_target = '0, mem_rd_data = '0;
  logic        mem_rd_req, Fetch_ready, fetch_busy, fetch_fault;
  logic [31:0] mem_addr, Cu_IR, Cu_PC;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: architectural PC and the last delivered instruction.
  logic [31:0] m_pc, m_ir, m_cpc;

  always #5 soc_clk = ~soc_clk;

  cu_if #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT), .NOP_INSTR(NOP_INSTR)) dut (
    .soc_clk(soc_clk), .reset(reset), .fetch_start(fetch_start),
    .pc_advance(pc_advance), .pc_increment(pc_increment),
    .pc_load(pc_load), .pc_target(pc_target), .IDU_stall(IDU_stall),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .Cu_IR(Cu_IR), .Cu_PC(Cu_PC),
    .Fetch_ready(Fetch_ready), .fetch_busy(fetch_busy), .fetch_fault(fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge soc_clk);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // op: 0 none, 1 step, 2 redirect, 3 both (redirect wins)
  task automatic apply_op(input int op, input logic [31:0] inc, input logic [31:0] tgt);
    pc_increment = inc;
    pc_target    = tgt;
    pc_advance   = (op == 1 || op == 3);
    pc_load      = (op == 2 || op == 3);
    if (op == 1)      m_pc = m_pc + inc;
    else if (op >= 2) m_pc = tgt;
  endtask

  task automatic clear_ops();
    pc_advance = 1'b0;
    pc_load    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_start = 1'b0; clear_ops(); IDU_stall = 1'b0; mem_rd_valid = 1'b0;
    tick(); tick();
    m_pc = RESET_PC; m_ir = NOP_INSTR; m_cpc = RESET_PC;
    check("rst_req", {31'd0, mem_rd_req}, 32'd0);
    check("rst_addr", mem_addr, RESET_PC);
    check("rst_ir", Cu_IR, NOP_INSTR);
    check("rst_cpc", Cu_PC, RESET_PC);
    check("rst_rdy", {31'd0, Fetch_ready}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b0;
  endtask

  // flush: 0 none, 1 redirect during REQ, 2 during first WAIT cycle, 3 during HOLD
  task automatic fetch(input int op, input logic [31:0] inc, input logic [31:0] tgt,
                       input logic [31:0] data, input int lat, input int stall_n,
                       input int flush, input logic [31:0] ftgt);
    logic [31:0] req_pc;
    bit discard;
    discard = (flush == 1 || flush == 2);
    fetch_start = 1'b1;
    apply_op(op, inc, tgt);
    tick();
    fetch_start = 1'b0; clear_ops();
    req_pc = m_pc;
    check("req", {31'd0, mem_rd_req}, 32'd1);
    check("req_addr", mem_addr, word_of(req_pc));
    check("busy", {31'd0, fetch_busy}, 32'd1);
    if ($urandom_range(1) == 1) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = $urandom;
    end
    if (flush == 1) apply_op(2, 0, ftgt);
    tick();
    mem_rd_valid = 1'b0; clear_ops();
    check("req_pulse", {31'd0, mem_rd_req}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      if (flush == 2 && i == 0) apply_op(2, 0, ftgt);
      tick();
      clear_ops();
      check("wait_rdy", {31'd0, Fetch_ready}, 32'd0);
    end
    if (flush == 2 && lat == 0) apply_op(2, 0, ftgt);
    mem_rd_valid = 1'b1;
    mem_rd_data  = data;
    IDU_stall    = (stall_n > 0);
    tick();
    mem_rd_valid = 1'b0; clear_ops();
    if (discard) begin
      IDU_stall = 1'b0;
      check("squash_rdy", {31'd0, Fetch_ready}, 32'd0);
      check("squash_ir", Cu_IR, m_ir);
      check("squash_idle", {31'd0, fetch_busy}, 32'd0);
    end else if (stall_n == 0) begin
      m_ir = data; m_cpc = req_pc;
      check("rdy", {31'd0, Fetch_ready}, 32'd1);
      check("ir", Cu_IR, m_ir);
      check("cpc", Cu_PC, m_cpc);
      tick();
      check("rdy_pulse", {31'd0, Fetch_ready}, 32'd0);
    end else begin
      m_ir = data; m_cpc = req_pc;
      for (int k = 0; k < stall_n; k++) begin
        check("hold_rdy", {31'd0, Fetch_ready}, 32'd0);
        check("hold_ir", Cu_IR, m_ir);
        if (k == stall_n - 1) begin
          if (flush == 3) apply_op(2, 0, ftgt);
          else IDU_stall = 1'b0;
        end
        tick();
        clear_ops();
      end
      IDU_stall = 1'b0;
      if (flush == 3) begin
        m_ir = NOP_INSTR;
        check("hflush_rdy", {31'd0, Fetch_ready}, 32'd0);
        check("hflush_ir", Cu_IR, m_ir);
        check("hflush_idle", {31'd0, fetch_busy}, 32'd0);
      end else begin
        check("hold_rel_rdy", {31'd0, Fetch_ready}, 32'd1);
        check("hold_rel_ir", Cu_IR, m_ir);
        check("hold_rel_cpc", Cu_PC, m_cpc);
        tick();
        check("hold_rel_pulse", {31'd0, Fetch_ready}, 32'd0);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Best-case latency and PC reporting.
    fetch(0, 0, 0, 32'h0050_0093, 0, 0, 0, 0);
    // Step coinciding with fetch_start, then a redirect.
    fetch(1, 32'd4, 0, 32'h1111_2222, 1, 0, 0, 0);
    check("t2_addr", word_of(m_pc), 32'h4);
    fetch(2, 0, 32'h100, 32'h3333_4444, 0, 0, 0, 0);
    check("t2_load", m_cpc, 32'h100);
    // Decode stall held 5 cycles.
    fetch(0, 0, 0, 32'hCAFE_0001, 2, 5, 0, 0);
    // Redirect in WAIT, in REQ and in HOLD.
    fetch(0, 0, 0, 32'hDEAD_0002, 3, 0, 2, 32'h80);
    fetch(0, 0, 0, 32'hBEEF_0003, 0, 0, 0, 0);
    check("t4_addr", m_cpc, 32'h80);
    fetch(0, 0, 0, 32'h0BAD_0004, 2, 0, 1, 32'h200);
    fetch(0, 0, 0, 32'h0BAD_0005, 1, 3, 3, 32'h300);
    fetch(0, 0, 0, 32'h1234_5678, 0, 0, 0, 0);

    // Timeout into sticky fault.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("to_req", {31'd0, mem_rd_req}, 32'd1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) check("to_not_yet", {31'd0, fetch_fault}, 32'd0);
    end
    check("to_fault", {31'd0, fetch_fault}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      fetch_start = 1'b1; mem_rd_valid = 1'b1; apply_op(2, 0, 32'h40);
      tick();
      check("fault_noreq", {31'd0, mem_rd_req}, 32'd0);
      check("fault_rdy", {31'd0, Fetch_ready}, 32'd0);
      check("fault_held", {31'd0, fetch_fault}, 32'd1);
    end
    fetch_start = 1'b0; mem_rd_valid = 1'b0; clear_ops();
    do_reset();
    fetch(0, 0, 0, 32'h0000_0777, 0, 0, 0, 0);
    check("post_rst_pc", m_cpc, RESET_PC);

    // PC wrap and misaligned redirect.
    apply_op(2, 0, 32'hFFFF_FFFC);
    tick();
    clear_ops();
    fetch(1, 32'd4, 0, 32'h0000_0999, 0, 0, 0, 0);
    check("wrap_pc", m_cpc, 32'h0);
`ifdef CU_IF_MISALIGN_CHECK_EN
    fetch_start = 1'b1; apply_op(2, 0, 32'h102);
    tick();
    fetch_start = 1'b0; clear_ops();
    check("mis_noreq", {31'd0, mem_rd_req}, 32'd0);
    tick();
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
`else
    fetch(2, 0, 32'h102, 32'h0000_0AAA, 1, 0, 0, 0);
    check("mis_cpc", Cu_PC, 32'h102);
`endif
    do_reset();

    // Randomized transactions with aligned steps and targets.
    for (int it = 0; it < 80; it++) begin
      int nidle, op, fl, st;
      logic [31:0] inc, tgt, ftgt;
      nidle = $urandom_range(2);
      for (int j = 0; j < nidle; j++) begin
        apply_op($urandom_range(3), {$urandom_range(32'hFFFF_FFFF) >> 2, 2'b00},
                 {$urandom_range(32'hFFFF_FFFF) >> 2, 2'b00});
        tick();
        clear_ops();
        check("idle_nordy", {31'd0, Fetch_ready}, 32'd0);
      end
      op   = $urandom_range(3);
      inc  = {$urandom_range(32'hFFFF_FFFF) >> 2, 2'b00};
      tgt  = {$urandom_range(32'hFFFF_FFFF) >> 2, 2'b00};
      ftgt = {$urandom_range(32'hFFFF_FFFF) >> 2, 2'b00};
      st   = ($urandom_range(2) == 0) ? int'($urandom_range(1, 4)) : 0;
      fl   = ($urandom_range(3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (fl == 3 && st == 0) fl = 0;
      fetch(op, inc, tgt, $urandom, $urandom_range(6), st, fl, ftgt);
    end
    check("end_fault", {31'd0, fetch_fault}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
